spi_sram_responder: RTL and testbench

- SPI mode-0 target that emulates a 128 KB serial SRAM (23LC1024-style command set) on the cartridge side of the save link.
- It answers the initiator's READ (0x03 + 24-bit address), WRITE (0x02) and RDMR (0x05) transactions.
- It drives a synchronous byte-wide memory port.
- SPI pins are asynchronous to clk and are oversampled by the internal 53.20 MHz oscillator clock.

---
 rtl/spi_sram_responder.sv | 215 +++++++++++++++++++++
 tb/tb_spi_sram_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_sram_responder : SPI mode-0 target emulating a 23LC1024-style serial    |
// | SRAM (READ/WRITE/RDMR) on a synchronous byte-wide memory port. Rev 1.0      |
// +-----------------------------------------------------------------------------+
module spi_sram_responder #(
  parameter int          ADDR_BITS   = 17,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  MODE_REG    = 8'h40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_cs_n,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  input  logic                 spi_hold_n,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_MR_DATA, S_IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [1:0]             hist_q;
  logic                   cs_s, sclk_s, mosi_s, hold_s;
  logic                   cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [4:0]             bit_cnt;
  logic [23:0]            rx_shift, rx_next;
  logic [7:0]             tx_shift, prefetch;
  logic [ADDR_BITS-1:0]   addr_q, addr_inc;
  logic                   rd_q, rd_wait_q, pf_dest_q, miso_q;

  // Pins packed as {cs_n, sclk, mosi, hold_n}; only cs_n and sclk need edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= {spi_cs_n, spi_sclk, spi_mosi, spi_hold_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1][3:2];
    end
  end

  assign {cs_s, sclk_s, mosi_s, hold_s} = sync_q[SYNC_STAGES-1];
  assign cs_rise   =  cs_s & ~hist_q[1];
  assign cs_fall   = ~cs_s &  hist_q[1];
  assign sclk_rise =  sclk_s & ~hist_q[0] & hold_s;
  assign sclk_fall = ~sclk_s &  hist_q[0] & hold_s;
  assign rx_next   = {rx_shift[22:0], mosi_s};
  assign addr_inc  = addr_q + ADDR_BITS'(1);
  assign spi_miso  = miso_q & spi_miso_oe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    spi_miso_oe = (state_q == S_RD_DATA) || (state_q == S_MR_DATA);
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (cs_fall) state_d = S_CMD;
      S_CMD: begin
        if (sclk_rise && bit_cnt == 5'd7) begin
          case (rx_next[7:0])
            OP_READ, OP_WRITE: state_d = S_ADDR;
            OP_RDMR:           state_d = S_MR_DATA;
            default:           state_d = S_IGNORE;
          endcase
        end
      end
      S_ADDR: if (sclk_rise && bit_cnt == 5'd23) state_d = rd_q ? S_RD_DATA : S_WR_DATA;
      default: ;
    endcase
    if (cs_rise) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      prefetch  <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      rd_wait_q <= 1'b0;
      pf_dest_q <= 1'b0;
      miso_q    <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cmd_err   <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      cmd_err   <= 1'b0;
      rd_wait_q <= mem_rd;
      // Read data lands two clocks after the strobe: first into tx_shift, then prefetch.
      if (rd_wait_q && state_q == S_RD_DATA) begin
        if (!pf_dest_q) begin
          tx_shift  <= mem_rdata;
          pf_dest_q <= 1'b1;
          addr_q    <= addr_inc;
          mem_addr  <= addr_inc;
          mem_rd    <= 1'b1;
        end else begin
          prefetch  <= mem_rdata;
        end
      end
      case (state_q)
        S_IDLE: if (cs_fall) bit_cnt <= '0;
        S_CMD: begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              case (rx_next[7:0])
                OP_READ:  rd_q <= 1'b1;
                OP_WRITE: rd_q <= 1'b0;
                OP_RDMR:  tx_shift <= MODE_REG;
                default:  cmd_err <= 1'b1;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              addr_q  <= rx_next[ADDR_BITS-1:0];
              if (rd_q) begin
                mem_addr  <= rx_next[ADDR_BITS-1:0];
                mem_rd    <= 1'b1;
                pf_dest_q <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        S_RD_DATA: begin
          if (sclk_fall) begin
            if (bit_cnt == 5'd8) begin
              miso_q   <= prefetch[7];
              tx_shift <= {prefetch[6:0], 1'b0};
              bit_cnt  <= 5'd1;
              addr_q   <= addr_inc;
              mem_addr <= addr_inc;
              mem_rd   <= 1'b1;
            end else begin
              miso_q   <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
        end
        S_WR_DATA: begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == 5'd7) begin
              bit_cnt   <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= addr_q;
              mem_wdata <= rx_next[7:0];
              addr_q    <= addr_inc;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        S_MR_DATA: begin
          if (sclk_fall) begin
            if (bit_cnt == 5'd8) begin
              miso_q   <= MODE_REG[7];
              tx_shift <= {MODE_REG[6:0], 1'b0};
              bit_cnt  <= 5'd1;
            end else begin
              miso_q   <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
      // Deselect drops any partial byte; a byte completed in this same clk has already committed.
      if (cs_rise) begin
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_spi_sram_responder : directed bench for spi_sram_responder. Rev 1.0      |
// +-----------------------------------------------------------------------------+
module tb_spi_sram_responder;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0, spi_hold_n = 1'b1;
  logic        spi_miso, spi_miso_oe, mem_rd, mem_we, busy, cmd_err;
  logic [16:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem [0:131071];
  logic [16:0] wlog_addr [0:15];
  logic [7:0]  wlog_data [0:15];
  int          checks = 0, errors = 0;
  int          we_count = 0, rd_count = 0, err_count = 0;

  always #5 clk = ~clk;

  spi_sram_responder #(.ADDR_BITS(17), .SYNC_STAGES(2), .MODE_REG(8'h40)) dut (
    .clk(clk), .rst(rst),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_hold_n(spi_hold_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .cmd_err(cmd_err)
  );

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_count  <= rd_count + 1;
    end
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (we_count < 16) begin
        wlog_addr[we_count[3:0]] <= mem_addr;
        wlog_data[we_count[3:0]] <= mem_wdata;
      end
      we_count <= we_count + 1;
    end
    if (cmd_err) err_count <= err_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx,
                      output logic oe_all, output logic oe_any);
    rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      tick(HALF);
      rx = {rx[6:0], spi_miso};
      oe_all = oe_all & spi_miso_oe;
      oe_any = oe_any | spi_miso_oe;
      spi_sclk = 1'b1;
      tick(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(2*HALF);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    logic oa, oy;
    xfer(op, 8, d, oa, oy);
    xfer(a[23:16], 8, d, oa, oy);
    xfer(a[15:8], 8, d, oa, oy);
    xfer(a[7:0], 8, d, oa, oy);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 32'({spi_miso, spi_miso_oe, mem_rd, mem_we, busy, cmd_err, mem_addr, mem_wdata}), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [7:0] b0, b1, hi, lo;
    logic oa, oy, oy_acc, held;
    int e0, r0, w0, diffs;

    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h00010] = 8'hA5;
    mem[17'h1FFFF] = 8'h3C;
    mem[17'h00000] = 8'hC3;
    mem[17'h00020] = 8'h9E;
    mem[17'h00021] = 8'h5A;

    tick(5);
    check_idle_outputs("reset_outputs");
    rst = 1'b0;
    tick(4);
    check_idle_outputs("post_reset_idle");

    // Single read of 0xA5.
    cs_low();
    send_cmd(8'h03, 24'h000010);
    check("busy_selected", 32'(busy), 32'd1);
    xfer(8'h00, 8, b0, oa, oy);
    check("read_a5_data", 32'(b0), 32'hA5);
    check("read_a5_oe", 32'(oa), 32'd1);
    cs_high();
    check("deselect_oe_busy", 32'({spi_miso_oe, busy, spi_miso}), 32'd0);

    // Sequential read across the top-address wrap.
    cs_low();
    send_cmd(8'h03, 24'hFFFFFF);
    xfer(8'h00, 8, b0, oa, oy);
    xfer(8'h00, 8, b1, oy, oy);
    check("seq_read_byte0", 32'(b0), 32'h3C);
    check("seq_read_byte1_wrap", 32'(b1), 32'hC3);
    cs_high();

    // Write two bytes, then a 3-bit partial byte that must be discarded.
    w0 = we_count;
    cs_low();
    send_cmd(8'h02, 24'h000100);
    xfer(8'h11, 8, b0, oa, oy_acc);
    xfer(8'h22, 8, b0, oa, oy);
    oy_acc = oy_acc | oy;
    xfer(8'hE0, 3, b0, oa, oy);
    oy_acc = oy_acc | oy;
    cs_high();
    check("write_we_count", 32'(we_count - w0), 32'd2);
    check("write0_addr_data", {7'd0, wlog_addr[w0[3:0]], wlog_data[w0[3:0]]}, {7'd0, 17'h00100, 8'h11});
    check("write1_addr_data", {7'd0, wlog_addr[4'(w0 + 1)], wlog_data[4'(w0 + 1)]}, {7'd0, 17'h00101, 8'h22});
    check("write_oe_off", 32'(oy_acc), 32'd0);
    cs_low();
    send_cmd(8'h03, 24'h000100);
    xfer(8'h00, 8, b0, oa, oy);
    xfer(8'h00, 8, b1, oa, oy);
    check("readback_written", 32'({b0, b1}), 32'h1122);
    cs_high();

    // Hold in mid-read: SCLK toggles must not advance the byte.
    cs_low();
    send_cmd(8'h03, 24'h000020);
    xfer(8'h00, 4, hi, oa, oy);
    tick(HALF);
    held = spi_miso;
    check("hold_pre_bit", 32'(held), 32'd1);
    spi_hold_n = 1'b0;
    tick(HALF);
    diffs = 0;
    for (int t = 0; t < 20; t++) begin
      spi_sclk = ~spi_sclk;
      tick(HALF);
      if (spi_miso !== held) diffs++;
    end
    check("hold_miso_stable", 32'(diffs), 32'd0);
    spi_hold_n = 1'b1;
    tick(HALF);
    xfer(8'h00, 4, lo, oa, oy);
    check("hold_byte_complete", 32'({hi[3:0], lo[3:0]}), 32'h9E);
    xfer(8'h00, 8, b1, oa, oy);
    check("hold_next_byte", 32'(b1), 32'h5A);
    cs_high();

    // Unsupported opcode followed by junk bytes.
    e0 = err_count; r0 = rd_count; w0 = we_count;
    cs_low();
    xfer(8'h9F, 8, b0, oa, oy_acc);
    xfer(8'h03, 8, b0, oa, oy);
    oy_acc = oy_acc | oy;
    xfer(8'h02, 8, b0, oa, oy);
    oy_acc = oy_acc | oy;
    cs_high();
    check("bad_op_cmd_err_once", 32'(err_count - e0), 32'd1);
    check("bad_op_no_mem_access", 32'({rd_count - r0, we_count - w0}), 32'd0);
    check("bad_op_oe_off", 32'(oy_acc), 32'd0);
    cs_low();
    send_cmd(8'h03, 24'h000010);
    xfer(8'h00, 8, b0, oa, oy);
    check("read_after_bad_op", 32'(b0), 32'hA5);
    cs_high();

    // RDMR repeats the mode register.
    cs_low();
    xfer(8'h05, 8, b0, oa, oy);
    xfer(8'h00, 8, b0, oa, oy);
    xfer(8'h00, 8, b1, oy, oy);
    check("rdmr_bytes", 32'({b0, b1}), 32'h4040);
    check("rdmr_oe", 32'(oa), 32'd1);
    cs_high();

    // Reset in the middle of a write byte.
    w0 = we_count;
    cs_low();
    send_cmd(8'h02, 24'h000200);
    xfer(8'hEE, 5, b0, oa, oy);
    rst = 1'b1;
    xfer(8'hC0, 3, b0, oa, oy);
    check_idle_outputs("rst_mid_write_outputs");
    rst = 1'b0;
    tick(4);
    check_idle_outputs("after_rst_idle");
    cs_high();
    check("rst_mid_write_no_we", 32'(we_count - w0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
